mdu_seq: RTL and testbench

//  Sequential multiply/divide unit for the RISC-V M extension, sitting beside the single-cycle ALU in EX.

---
 rtl/mdu_seq.sv | 146 ++++++++++++++
 tb/tb_mdu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Radix-2 sequential multiply/divide unit for the RISC-V M extension, valid/ready on both sides.
// Define MDU_FAST_MUL_EN to run multiplies through a single registered multiplier instead.
//
//  state | meaning
//  IDLE  | waiting for an op, InReady high
//  CALC  | one shift-add / shift-subtract iteration per edge
//  FIX   | sign correction and high/low select into Result
//  DONE  | Result held until OutReady
module mdu_seq #(
    parameter int WORDS    = 32,
    parameter int CTRLBITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic [CTRLBITS-1:0] Op,
    input  logic [WORDS-1:0]    A,
    input  logic [WORDS-1:0]    B,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [WORDS-1:0]    Result,
    output logic                Busy
);

    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    localparam logic [WORDS-1:0] MOST_NEG = {1'b1, {(WORDS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nx;

    logic [CTRLBITS-1:0] op_q;
    logic [WORDS-1:0]    b_mag;
    logic [2*WORDS-1:0]  acc;
    logic                neg_q;
    logic [CW-1:0]       count;

    logic                accept, is_div, is_rem, signed_a, signed_b, a_neg, b_neg, neg_in;
    logic [WORDS-1:0]    a_abs, b_abs, special_res, fast_res;
    logic                div_zero, div_ovf, fast_hit;

    logic [WORDS:0]      mul_sum, div_sh, div_diff;
    logic                div_ok;
    logic [2*WORDS-1:0]  mul_nx, div_nx, prod_fix;
    logic [WORDS-1:0]    q_fix, r_fix, fix_res;

    assign InReady  = (state == IDLE) && !Flush;
    assign OutValid = (state == DONE);
    assign Busy     = (state != IDLE);
    assign accept   = InValid && InReady;

    always_comb begin
        is_div   = Op[2];
        is_rem   = Op[2] && Op[1];
        signed_a = (Op == CTRLBITS'(1)) || (Op == CTRLBITS'(2)) ||
                   (Op == CTRLBITS'(4)) || (Op == CTRLBITS'(6));
        signed_b = (Op == CTRLBITS'(1)) || (Op == CTRLBITS'(4)) || (Op == CTRLBITS'(6));
        a_neg    = signed_a && A[WORDS-1];
        b_neg    = signed_b && B[WORDS-1];
        a_abs    = a_neg ? -A : A;
        b_abs    = b_neg ? -B : B;
        // remainder follows the dividend; quotient and product follow the sign mismatch
        neg_in   = is_rem ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (B == '0);
        div_ovf  = ((Op == CTRLBITS'(4)) || (Op == CTRLBITS'(6))) && (A == MOST_NEG) && (B == '1);
        if (div_zero)
            special_res = is_rem ? A : '1;
        else
            special_res = is_rem ? '0 : A;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*WORDS+1:0] fast_a, fast_b, fast_prod;
    always_comb begin
        fast_a    = {{(WORDS+2){signed_a && A[WORDS-1]}}, A};
        fast_b    = {{(WORDS+2){signed_b && B[WORDS-1]}}, B};
        fast_prod = fast_a * fast_b;
        fast_hit  = !is_div;
        fast_res  = (Op == CTRLBITS'(0)) ? fast_prod[WORDS-1:0] : fast_prod[2*WORDS-1:WORDS];
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    always_comb begin
        mul_sum  = {1'b0, acc[2*WORDS-1:WORDS]} + (acc[0] ? {1'b0, b_mag} : '0);
        mul_nx   = {mul_sum, acc[WORDS-1:1]};
        div_sh   = acc[2*WORDS-1:WORDS-1];
        div_diff = div_sh - {1'b0, b_mag};
        div_ok   = !div_diff[WORDS];
        div_nx   = {(div_ok ? div_diff[WORDS-1:0] : div_sh[WORDS-1:0]), acc[WORDS-2:0], div_ok};
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[WORDS-1:0] : acc[WORDS-1:0];
        r_fix    = neg_q ? -acc[2*WORDS-1:WORDS] : acc[2*WORDS-1:WORDS];
        if (op_q[2])
            fix_res = op_q[1] ? r_fix : q_fix;
        else
            fix_res = (op_q == CTRLBITS'(0)) ? prod_fix[WORDS-1:0] : prod_fix[2*WORDS-1:WORDS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (div_zero || div_ovf || fast_hit) ? DONE : CALC;
            CALC: if (count == LAST) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (OutReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (Flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            b_mag  <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            count  <= '0;
            Result <= '0;
        end else if (accept) begin
            op_q  <= Op;
            b_mag <= b_abs;
            acc   <= {{WORDS{1'b0}}, a_abs};
            neg_q <= neg_in;
            count <= '0;
            if (div_zero || div_ovf) Result <= special_res;
            else if (fast_hit)       Result <= fast_res;
        end else if (state == CALC && !Flush) begin
            acc   <= op_q[2] ? div_nx : mul_nx;
            count <= count + 1'b1;
        end else if (state == FIX && !Flush) begin
            Result <= fix_res;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq (WORDS=32): results, latency, stall, flush and async reset.
module tb_mdu_seq;

    logic        clk, rst_n, Flush, InValid, InReady, OutValid, OutReady, Busy;
    logic [2:0]  Op;
    logic [31:0] A, B, Result;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    mdu_seq #(.WORDS(32), .CTRLBITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .Op(Op), .A(A), .B(B), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the unit idle; leaves it idle again.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        InValid = 1'b1; Op = op; A = a; B = b;
        @(posedge clk); #1;
        InValid = 1'b0; Op = ~op; A = 32'hDEADBEEF; B = 32'h5A5A5A5A;
        lat = 0;
        while (!OutValid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_res"}, Result, exp);
        chk({tag, "_lat"}, lat, exp_lat);
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        chk({tag, "_idle"}, {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Op = 3'd0; A = '0; B = '0;
        #12;
        chk("rst_inready", {31'b0, InReady}, 32'd1);
        chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_result", Result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("div_neg7_2",  3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("rem_neg7_2",  3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("divu_by0",    3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 0);
        run_op("remu_by0",    3'd7, 32'h1234, 32'd0, 32'h00001234, 0);
        run_op("div_by0",     3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 0);
        run_op("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op("divu_100_7",  3'd5, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7",  3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_7_neg2",  3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("rem_7_neg2",  3'd6, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op("divu_big",    3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33);
        run_op("mulh_min",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("mulhu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_op("mulhsu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        run_op("mul_max",     3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);
        run_op("mul_7_neg3",  3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulh_7_neg3", 3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, MUL_LAT);
        run_op("mulhu_7_neg3",3'd3, 32'd7, 32'hFFFFFFFD, 32'h00000006, MUL_LAT);

        // Back-pressure: Result held, no accept while DONE even with InValid high
        InValid = 1'b1; Op = 3'd5; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        A = 32'd9; B = 32'd3;
        seen = 0;
        while (!OutValid && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, OutValid}, 32'd1);
            chk("stall_result", Result, 32'd14);
            chk("stall_inready", {31'b0, InReady}, 32'd0);
            @(posedge clk); #1;
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        chk("stall_release_valid", {31'b0, OutValid}, 32'd0);
        chk("stall_release_busy", {31'b0, Busy}, 32'd0);

        // Flush at CALC iteration 10
        InValid = 1'b1; Op = 3'd5; A = 32'd1000; B = 32'd3;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_busy_before", {31'b0, Busy}, 32'd1);
        Flush = 1'b1;
        #1;
        chk("flush_inready", {31'b0, InReady}, 32'd0);
        @(posedge clk); #1;
        Flush = 1'b0;
        chk("flush_busy", {31'b0, Busy}, 32'd0);
        chk("flush_result_kept", Result, 32'd14);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (OutValid) seen++;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", seen, 32'd0);

        // Async reset mid-CALC
        InValid = 1'b1; Op = 3'd4; A = 32'hFFFFFFF9; B = 32'd2;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, Busy}, 32'd0);
        chk("arst_valid", {31'b0, OutValid}, 32'd0);
        chk("arst_result", Result, 32'd0);
        chk("arst_inready", {31'b0, InReady}, 32'd1);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (OutValid) seen++;
        end
        chk("arst_no_valid", seen, 32'd0);

        run_op("post_rst_div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
